// File: rtl/platform_field.sv
// Platform set of the game field: landing detection, field scrolling with
// platform recycling, per-pixel platform flag and running score.
module platform_field #(
  parameter int unsigned NUM_PLAT    = 8,
  parameter int unsigned H           = 480,
  parameter int unsigned X_MIN       = 140,
  parameter int unsigned PLAT_W      = 57,
  parameter int unsigned PLAT_H      = 10,
  parameter int unsigned DOODLE_W    = 32,
  parameter int unsigned DOODLE_H    = 32,
  parameter int unsigned SPACING     = 60,
  parameter int unsigned SCROLL_LINE = 160,
  parameter int unsigned MAX_SCROLL  = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  frame_clk_edge,
  input  logic        game_active,
  input  logic [9:0]  doodle_x,
  input  logic [9:0]  doodle_y,
  input  logic        doodle_falling,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        plat_on,
  output logic        bounce,
  output logic        scroll_valid,
  output logic [9:0]  scroll_amt,
  output logic [15:0] score
);

  localparam int unsigned IDXW    = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam int unsigned FIRST_Y = H - 20;
  localparam int unsigned WRAP    = NUM_PLAT * SPACING;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PLAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    CHECK,
    SCROLL,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [IDXW-1:0] idx, idx_n;

  logic [9:0]  plat_x [NUM_PLAT];
  logic [9:0]  plat_y [NUM_PLAT];
  logic [15:0] lfsr;
  logic [9:0]  snap_x, snap_y;
  logic        snap_fall;
  logic        hit;
  logic [9:0]  amt;

  logic        lfsr_fb_c;
  logic [9:0]  x_new_c;
  logic [9:0]  setup_y_c;
  logic [10:0] cur_x_c, cur_y_c, foot_c, snap_x11_c, ny_c;
  logic        hit_c;
  logic [9:0]  amt_c;
  logic [16:0] score_sum_c;
  logic        plat_on_c;
  logic        frame_edge_c;

  assign frame_edge_c = (frame_clk_edge == 2'b01);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic; dropping game_active abandons any sequence in flight
  always_comb begin
    state_n = state;
    idx_n   = idx;
    if (state != IDLE && !game_active) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (game_active) begin
            state_n = SETUP;
            idx_n   = '0;
          end
        end
        SETUP: begin
          if (idx == LAST_IDX) begin
            state_n = RUN;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDXW'(1);
          end
        end
        RUN: begin
          if (frame_edge_c) begin
            state_n = CHECK;
            idx_n   = '0;
          end
        end
        CHECK: begin
          if (idx == LAST_IDX) begin
            state_n = SCROLL;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDXW'(1);
          end
        end
        SCROLL: begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDXW'(1);
          end
        end
        DONE: begin
          state_n = RUN;
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Per-platform arithmetic, all 11-bit so sums never wrap
  always_comb begin
    lfsr_fb_c   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    x_new_c     = 10'(X_MIN) + 10'(lfsr[7:0]);
    setup_y_c   = 10'(FIRST_Y - SPACING * 32'(idx));
    cur_x_c     = {1'b0, plat_x[idx]};
    cur_y_c     = {1'b0, plat_y[idx]};
    snap_x11_c  = {1'b0, snap_x};
    foot_c      = {1'b0, snap_y} + 11'(DOODLE_H);
    hit_c       = snap_fall
                  && (foot_c >= cur_y_c)
                  && (foot_c < cur_y_c + 11'(PLAT_H))
                  && (snap_x11_c + 11'(DOODLE_W) > cur_x_c)
                  && (snap_x11_c < cur_x_c + 11'(PLAT_W));
    ny_c        = cur_y_c + {1'b0, amt};
    score_sum_c = {1'b0, score} + 17'(amt);
  end

  // Scroll amount from the snapshot, capped per frame
  always_comb begin
    amt_c = '0;
    if (snap_y < 10'(SCROLL_LINE)) begin
      amt_c = 10'(SCROLL_LINE) - snap_y;
      if (amt_c > 10'(MAX_SCROLL)) begin
        amt_c = 10'(MAX_SCROLL);
      end
    end
  end

  // Pixel hit test against every platform
  always_comb begin
    plat_on_c = 1'b0;
    for (int unsigned i = 0; i < NUM_PLAT; i++) begin
      if ((DrawX >= plat_x[i]) && ({1'b0, DrawX} < {1'b0, plat_x[i]} + 11'(PLAT_W)) &&
          (DrawY >= plat_y[i]) && ({1'b0, DrawY} < {1'b0, plat_y[i]} + 11'(PLAT_H))) begin
        plat_on_c = 1'b1;
      end
    end
  end

  // Datapath; the DONE-cycle outputs are loaded on the final SCROLL step
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr         <= 16'hACE1;
      for (int unsigned i = 0; i < NUM_PLAT; i++) begin
        plat_x[i] <= '0;
        plat_y[i] <= '0;
      end
      snap_x       <= '0;
      snap_y       <= '0;
      snap_fall    <= 1'b0;
      hit          <= 1'b0;
      amt          <= '0;
      score        <= '0;
      scroll_amt   <= '0;
      bounce       <= 1'b0;
      scroll_valid <= 1'b0;
      plat_on      <= 1'b0;
    end else begin
      lfsr         <= {lfsr_fb_c, lfsr[15:1]};
      plat_on      <= plat_on_c;
      bounce       <= 1'b0;
      scroll_valid <= 1'b0;
      if (game_active) begin
        case (state)
          SETUP: begin
            plat_x[idx] <= x_new_c;
            plat_y[idx] <= setup_y_c;
          end
          RUN: begin
            if (frame_edge_c) begin
              snap_x    <= doodle_x;
              snap_y    <= doodle_y;
              snap_fall <= doodle_falling;
              hit       <= 1'b0;
            end
          end
          CHECK: begin
            if (hit_c) begin
              hit <= 1'b1;
            end
            if (idx == LAST_IDX) begin
              amt <= amt_c;
            end
          end
          SCROLL: begin
            if (ny_c >= 11'(H)) begin
              plat_y[idx] <= 10'(ny_c - 11'(WRAP));
              plat_x[idx] <= x_new_c;
            end else begin
              plat_y[idx] <= ny_c[9:0];
            end
            if (idx == LAST_IDX) begin
              bounce       <= hit;
              scroll_valid <= 1'b1;
              scroll_amt   <= amt;
              score        <= score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_platform_field.sv
// Randomized self-checking bench for platform_field against a frame-level
// model of the field, the LFSR sequence and the score.
module tb_platform_field;

  logic        Clk;
  logic        Reset;
  logic [1:0]  frame_clk_edge;
  logic        game_active;
  logic [9:0]  doodle_x;
  logic [9:0]  doodle_y;
  logic        doodle_falling;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        plat_on;
  logic        bounce;
  logic        scroll_valid;
  logic [9:0]  scroll_amt;
  logic [15:0] score;

  platform_field dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk_edge (frame_clk_edge),
    .game_active    (game_active),
    .doodle_x       (doodle_x),
    .doodle_y       (doodle_y),
    .doodle_falling (doodle_falling),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .plat_on        (plat_on),
    .bounce         (bounce),
    .scroll_valid   (scroll_valid),
    .scroll_amt     (scroll_amt),
    .score          (score)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int          errors = 0;
  int          checks = 0;
  int          mx [8];
  int          my [8];
  int          mscore = 0;
  int          mamt = 0;
  logic [15:0] mlfsr = 16'hACE1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form shifting right
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // One clock; afterwards mlfsr equals the LFSR value of the new cycle
  task automatic tick();
    logic r;
    r = Reset;
    @(posedge Clk);
    #1;
    mlfsr = r ? 16'hACE1 : lfsr_next(mlfsr);
  endtask

  function automatic int model_plat_on(input int px, input int py);
    for (int i = 0; i < 8; i++) begin
      if (px >= mx[i] && px < mx[i] + 57 && py >= my[i] && py < my[i] + 10) return 1;
    end
    return 0;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic probe(input int px, input int py);
    int exp;
    DrawX = 10'(px);
    DrawY = 10'(py);
    exp = model_plat_on(px, py);
    tick();
    check("plat_on", int'(plat_on), exp);
  endtask

  task automatic check_field();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("plat_x%0d", i), int'(dut.plat_x[i]), mx[i]);
      check($sformatf("plat_y%0d", i), int'(dut.plat_y[i]), my[i]);
    end
  endtask

  task automatic setup_field();
    game_active = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      mx[k] = 140 + int'(mlfsr[7:0]);
      my[k] = 460 - 60 * k;
      tick();
    end
    check_field();
    check("setup_score", int'(score), mscore);
  endtask

  // One frame starting in a RUN cycle T; optional stray edge / game drop at T+c
  task automatic frame(input int dx, input int dy, input bit fall,
                       input int extra_edge, input int drop_at);
    int foot, amt, ny;
    bit hit;
    foot = dy + 32;
    hit  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fall && my[i] <= foot && foot < my[i] + 10 && dx + 32 > mx[i] && dx < mx[i] + 57)
        hit = 1'b1;
    end
    amt = (dy < 160) ? ((160 - dy > 15) ? 15 : 160 - dy) : 0;

    doodle_x       = 10'(dx);
    doodle_y       = 10'(dy);
    doodle_falling = fall;
    frame_clk_edge = 2'b01;
    tick();
    frame_clk_edge = 2'b00;
    doodle_x       = 10'($urandom_range(0, 1023));
    doodle_y       = 10'($urandom_range(0, 1023));
    doodle_falling = ~fall;

    for (int c = 1; c <= 16; c++) begin
      if (c == drop_at) begin
        game_active = 1'b0;
        tick();
        frame_clk_edge = 2'b01;
        for (int k = 0; k < 12; k++) begin
          check("drop_pulses", int'({bounce, scroll_valid}), 0);
          tick();
        end
        frame_clk_edge = 2'b00;
        check("drop_score", int'(score), mscore);
        check("drop_amt", int'(scroll_amt), mamt);
        return;
      end
      if (c >= 9) begin
        ny = my[c - 9] + amt;
        if (ny >= 480) begin
          my[c - 9] = ny - 480;
          mx[c - 9] = 140 + int'(mlfsr[7:0]);
        end else begin
          my[c - 9] = ny;
        end
      end
      if (c == extra_edge) frame_clk_edge = 2'b01;
      tick();
      frame_clk_edge = 2'b00;
      if (c == 1 || c == 15) check("busy_pulses", int'({bounce, scroll_valid}), 0);
    end

    mscore = (mscore + amt > 65535) ? 65535 : mscore + amt;
    mamt   = amt;
    check("bounce", int'(bounce), int'(hit));
    check("scroll_valid", int'(scroll_valid), 1);
    check("scroll_amt", int'(scroll_amt), amt);
    check("score", int'(score), mscore);
    tick();
    check("after_pulses", int'({bounce, scroll_valid}), 0);
    check("amt_hold", int'(scroll_amt), amt);
    check_field();
  endtask

  initial begin
    int i, dx, dy;
    Reset          = 1'b1;
    game_active    = 1'b0;
    frame_clk_edge = 2'b00;
    doodle_x       = '0;
    doodle_y       = '0;
    doodle_falling = 1'b0;
    DrawX          = '0;
    DrawY          = '0;
    for (int k = 0; k < 8; k++) begin
      mx[k] = 0;
      my[k] = 0;
    end
    tick();
    tick();
    Reset = 1'b0;

    check("rst_bounce", int'(bounce), 0);
    check("rst_valid", int'(scroll_valid), 0);
    check("rst_amt", int'(scroll_amt), 0);
    check("rst_score", int'(score), 0);
    check("rst_plat_on", int'(plat_on), 0);
    probe(5, 5);
    probe(57, 5);
    probe(3, 10);
    frame_clk_edge = 2'b01;
    tick();
    frame_clk_edge = 2'b00;
    check("idle_edge", int'({bounce, scroll_valid}), 0);

    setup_field();

    // Landing, then the same spot while rising, then scrolling
    frame(mx[0], 433, 1'b1, -1, -1);
    frame(mx[0], 433, 1'b0, -1, -1);
    frame(300, 150, 1'b0, -1, -1);
    frame(300, 100, 1'b0, -1, -1);

    probe(mx[3], my[3]);
    probe(mx[3] + 57, my[3]);
    probe(mx[3] + 56, my[3] + 9);

    frame(200, 300, 1'b1, 5, -1);

    for (int n = 0; n < 25; n++) begin
      i = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) dy = $urandom_range(90, 300);
      else dy = clamp(my[i] - 32 + $urandom_range(0, 12), 0, 1023);
      dx = clamp(mx[i] - 40 + $urandom_range(0, 110), 0, 1023);
      frame(dx, dy, 1'($urandom_range(0, 3) != 0), -1, -1);
      for (int p = 0; p < 2; p++) begin
        i = $urandom_range(0, 7);
        probe(clamp(mx[i] - 5 + $urandom_range(0, 70), 0, 1023),
              clamp(my[i] - 2 + $urandom_range(0, 14), 0, 1023));
      end
    end

    frame(200, 300, 1'b1, -1, 10);
    setup_field();
    frame(250, 120, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
